jk_mod_counter: RTL and testbench
=================================

# jk_mod_counter

Modulo-N synchronous up/down counter whose state register is a bank of JK flip-flop cells, one per bit, with the J/K excitation logic generated inside the block. It is the stage directly upstream of the JK flip-flop: it computes the J and K drive for each cell from the requested operation (hold, count, load) and consumes the cells' Q outputs as its present state. Its terminal-count output cascades to further counter stages.

## Interface
- WIDTH, 4: counter width in bits; one JK cell per bit.
- MODULO, 10: count modulus. Legal range is 2 <= MODULO <= 2**WIDTH. Elaboration fails outside this range.

- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  asynchronous, active-low reset. 0 clears all state immediately. Release is sampled on clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load request; has priority over en.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  present count (Q of the JK cells).
- qn  output  WIDTH  bitwise complement of q (Qn of the cells).
- j_vec  output  WIDTH  combinational J drive presented to the cells this cycle.
- k_vec  output  WIDTH  combinational K drive presented to the cells this cycle.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse after a wrap-around.
- load_err  output  1  sticky flag for an out-of-range load.

## Operation
- **State.** The only state is q (held in the JK cells), wrap and load_err.
- **Cell rule per bit i at posedge clk:**
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- **Next-state selection**, in priority order:
  1. `load=1` and `din < MODULO`: next = din.
  2. `load=1` and `din >= MODULO`: next = q (hold); load_err <= 1.
  3. `load=0`, `en=1`, `up=1`: next = q+1, or 0 when q == MODULO-1.
  4. `load=0`, `en=1`, `up=0`: next = q-1, or MODULO-1 when q == 0.
  5. Otherwise: next = q (hold).
- **Excitation encoding.** For every bit, j_vec[i] and k_vec[i] must drive q[i] to next[i] using this fixed encoding:
  - q=0, next=0: J=0, K=0.
  - q=0, next=1: J=1, K=0.
  - q=1, next=0: J=0, K=1.
  - q=1, next=1: J=0, K=0.
  - The toggle code (J=K=1) is never issued. The bench checks this encoding exactly.
- **Arithmetic.** Arithmetic is unsigned, WIDTH bits. When MODULO == 2**WIDTH, the wrap is the natural overflow. The same select logic applies.
- **tc** = en & ~load & ((up & q==MODULO-1) | (~up & q==0)).
- **wrap** is set to 1 on the edge that performs an en-driven wrap (MODULO-1→0 up, 0→MODULO-1 down). It is 0 on every other edge. A load never raises wrap.
- **load_err:**
  - Set by an out-of-range load.
  - Cleared by the next in-range load or by reset.
  - Unaffected by counting.
- **Idle outputs.** `en=0` with `load=0` leaves q, wrap=0 and load_err unchanged. j_vec and k_vec are all zeros.
- **Invariant.** qn == ~q in every cycle, including during reset.

## Timing
- **Reset values** (rst=0, asynchronous, no clock needed):
  - q = 0, qn = all ones.
  - wrap = 0, load_err = 0.
  - j_vec = 0 and k_vec = 0 regardless of inputs.
  - tc = 0.
- **Reset release.** The first state change can occur on the first posedge clk with rst=1.
- **Reset mid-operation.** Asserting rst between edges clears q in the same cycle. A wrap pulse in flight is dropped. No partial update survives.
- **Latency.**
  - q, wrap and load_err change only on posedge clk, one cycle after their inputs are sampled.
  - tc, j_vec and k_vec are combinational from the current q and inputs, with zero latency.
- **Simultaneous load and en.** Load wins. Count and wrap are suppressed that cycle.
- **Cascading.** The next stage's en is tied to this stage's tc. The next stage steps on the same edge that this stage wraps.

## Test plan
1. **Reset and count up.** Hold rst=0 for 2 cycles: q=0, qn=4'hF, wrap=0. Then release and set en=1, up=1 for 10 cycles: q = 1..9, 0. tc=1 only while q=9. wrap=1 for exactly the cycle after q 9→0.
2. **Count down with wrap.** From q=0 with en=1, up=0: tc=1 at q=0. Next q=9 and wrap pulses. Then q = 8, 7, ... Check j_vec/k_vec on 0→9 are J=4'b1001, K=4'b0000.
3. **Load.**
   - load=1, din=6, en=1: q=6, wrap=0.
   - Then load=1, din=12: q holds 6 and load_err=1.
   - Then load=1, din=3: q=3 and load_err=0.
4. **Hold.** en=0, load=0 for 5 cycles at q=7: q stays 7, j_vec=k_vec=0, tc=0.
5. **Reset mid-count.** At q=5, drive rst low mid-cycle: q=0 and load_err=0 before the next edge. wrap stays 0.
6. **Full-range config.** With MODULO=16, WIDTH=4, count up through 15→0: wrap pulses once. Check at 15→0: J=0, K=4'hF. Checked every cycle throughout: qn==~q, and J&K is never 1 on any bit.

Source files
------------

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
//   Modulo-MODULO up/down counter whose state lives in a bank of JK cells,
//   one per bit. The block decides the next count (load / count / hold),
//   converts it into a J/K excitation per bit, and applies the JK
//   characteristic equation on every rising clock edge.
//
// Parameters
//   WIDTH    : counter width in bits (one JK cell per bit)
//   MODULO   : count modulus, 2 <= MODULO <= 2**WIDTH
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   en       in   count enable
//   up       in   1 = increment, 0 = decrement
//   load     in   parallel load request (wins over en)
//   din      in   parallel load value
//   q        out  present count (Q of the cells)
//   qn       out  complement of q (Qn of the cells)
//   j_vec    out  J drive presented to the cells this cycle
//   k_vec    out  K drive presented to the cells this cycle
//   tc       out  terminal count for cascading the next stage
//   wrap     out  one-cycle pulse after an enable-driven wrap-around
//   load_err out  sticky flag for an out-of-range load
// ---------------------------------------------------------------------------
module jk_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Reject an unusable modulus at elaboration time.
  generate
    if ((MODULO < 2) || (MODULO > (2 ** WIDTH))) begin : g_bad_modulo
      $error("jk_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
  endgenerate

  // MODULO may equal 2**WIDTH, so the range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] Q_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH - 1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_load_err;

  logic             w_din_ok;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tc;

  assign w_din_ok = ({1'b0, din} < MOD_EXT);

  // Next-count selection in priority order: load, count up, count down, hold.
  always_comb begin
    w_next = r_q;
    if (load) begin
      if (w_din_ok) begin
        w_next = din;
      end else begin
        w_next = r_q;
      end
    end else if (en) begin
      if (up) begin
        // At 2**WIDTH the explicit wrap coincides with natural overflow.
        if (r_q == Q_MAX) begin
          w_next = Q_ZERO;
        end else begin
          w_next = r_q + Q_ONE;
        end
      end else begin
        if (r_q == Q_ZERO) begin
          w_next = Q_MAX;
        end else begin
          w_next = r_q - Q_ONE;
        end
      end
    end else begin
      w_next = r_q;
    end
  end

  // Excitation: set bits that must rise, clear bits that must fall, never
  // toggle. Forced to zero while reset is held so nothing leaks to the cells.
  always_comb begin
    w_j  = {WIDTH{1'b0}};
    w_k  = {WIDTH{1'b0}};
    w_tc = 1'b0;
    if (rst) begin
      w_j  = ~r_q & w_next;
      w_k  = r_q & ~w_next;
      w_tc = en & ~load & ((up & (r_q == Q_MAX)) | (~up & (r_q == Q_ZERO)));
    end else begin
      w_j  = {WIDTH{1'b0}};
      w_k  = {WIDTH{1'b0}};
      w_tc = 1'b0;
    end
  end

  // JK cell bank: Q+ = J&~Q | ~K&Q for every bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= (w_j & ~r_q) | (~w_k & r_q);
    end
  end

  // Wrap pulse: tc already means "this edge wraps under en", load excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tc;
    end
  end

  // Sticky load error: only a load can set or clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_err <= 1'b0;
    end else if (load) begin
      r_load_err <= ~w_din_ok;
    end else begin
      r_load_err <= r_load_err;
    end
  end

  assign q        = r_q;
  assign qn       = ~r_q;
  assign j_vec    = w_j;
  assign k_vec    = w_k;
  assign tc       = w_tc;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
//   Directed bench for jk_mod_counter. Instance A uses MODULO=10, instance B
//   uses MODULO=16. Each directed row drives inputs just after a rising edge
//   and pushes the hand-computed expectation for mid-cycle (state left by the
//   previous edge plus combinational J/K/tc for the new inputs). A monitor
//   on the falling edge pops and compares, and also checks qn==~q and
//   J&K==0 on both instances every cycle.
// ---------------------------------------------------------------------------
module tb_jk_mod_counter;

  logic       clk;
  logic       rst;
  logic       en_a, up_a, load_a;
  logic [3:0] din_a;
  logic [3:0] q_a, qn_a, j_a, k_a;
  logic       tc_a, wrap_a, err_a;
  logic       en_b, up_b, load_b;
  logic [3:0] din_b;
  logic [3:0] q_b, qn_b, j_b, k_b;
  logic       tc_b, wrap_b, err_b;

  jk_mod_counter #(.WIDTH(4), .MODULO(10)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a), .din(din_a),
    .q(q_a), .qn(qn_a), .j_vec(j_a), .k_vec(k_a), .tc(tc_a), .wrap(wrap_a),
    .load_err(err_a)
  );

  jk_mod_counter #(.WIDTH(4), .MODULO(16)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b), .din(din_b),
    .q(q_b), .qn(qn_b), .j_vec(j_b), .k_vec(k_b), .tc(tc_b), .wrap(wrap_b),
    .load_err(err_b)
  );

  typedef struct {
    logic       sel;
    logic [3:0] q;
    logic       wrap;
    logic       err;
    logic [3:0] j;
    logic [3:0] k;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, then pop one expectation if present.
  always @(negedge clk) begin
    chk("qn_a", qn_a, ~q_a);
    chk("jk_a", j_a & k_a, 4'h0);
    chk("qn_b", qn_b, ~q_b);
    chk("jk_b", j_b & k_b, 4'h0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!e.sel) begin
        chk("q_a", q_a, e.q);
        chk("wrap_a", {3'b000, wrap_a}, {3'b000, e.wrap});
        chk("err_a", {3'b000, err_a}, {3'b000, e.err});
        chk("j_a", j_a, e.j);
        chk("k_a", k_a, e.k);
        chk("tc_a", {3'b000, tc_a}, {3'b000, e.tc});
      end else begin
        chk("q_b", q_b, e.q);
        chk("wrap_b", {3'b000, wrap_b}, {3'b000, e.wrap});
        chk("err_b", {3'b000, err_b}, {3'b000, e.err});
        chk("j_b", j_b, e.j);
        chk("k_b", k_b, e.k);
        chk("tc_b", {3'b000, tc_b}, {3'b000, e.tc});
      end
    end
  end

  // One directed row: drive the selected instance (other one idles) and push
  // the expected mid-cycle view of that instance.
  task automatic step(input logic s, input logic r, input logic ld, input logic en_v,
                      input logic up_v, input logic [3:0] d, input logic [3:0] eq,
                      input logic ew, input logic ee, input logic [3:0] ej,
                      input logic [3:0] ek, input logic et);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    if (!s) begin
      load_a = ld; en_a = en_v; up_a = up_v; din_a = d;
      load_b = 1'b0; en_b = 1'b0; up_b = 1'b0; din_b = 4'h0;
    end else begin
      load_b = ld; en_b = en_v; up_b = up_v; din_b = d;
      load_a = 1'b0; en_a = 1'b0; up_a = 1'b0; din_a = 4'h0;
    end
    x.sel = s; x.q = eq; x.wrap = ew; x.err = ee; x.j = ej; x.k = ek; x.tc = et;
    sb_q.push_back(x);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; din_a = 4'h0;
    en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; din_b = 4'h0;

    //    s     rst   ld    en    up    din   q     wrap  err   J        K        tc
    // Reset held with count requested: outputs stay quiet.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // Count up 0..9 and wrap.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 4'b0100, 4'b0011, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd6, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0, 1'b0, 4'b0000, 4'b1001, 1'b1);
    // Count down from 0: tc at 0, wraps to 9 with J=1001 K=0000.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'b1001, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 4'b0111, 4'b1000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0);
    // Load 6 with en=1 (load wins), bad load 12 holds, good load 3 clears err.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 4'd5, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd6, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd6, 1'b0, 1'b1, 4'b0001, 4'b0100, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd3, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0);
    // Hold at 7 for 5 cycles.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // Reach 5 with load_err set, then reset mid-cycle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd7, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd5, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // Full-range instance: load 14, count 14->15->0->1.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd14, 4'd0, 1'b0, 1'b0, 4'b1110, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
